// File: rtl/instr_fetch.sv
// instr_fetch: PC sequencing and instruction-memory fetch feeding a single decode slot.
// Optional macro FETCH_TIMEOUT_EN bounds the FETCH wait and parks the block in ERR on expiry.
module instr_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_3000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        Imem_req,
  output logic [31:0] Imem_addr,
  input  logic        Imem_rdy,
  input  logic [31:0] Imem_rdata,
  output logic [31:0] Instr,
  output logic [15:0] Instr_imm,
  output logic        Instr_valid,
  input  logic        Instr_ack,
  input  logic        Branch_taken,
  input  logic [31:0] Ex_offset,
  input  logic        Jump,
  input  logic [25:0] Jump_target,
  output logic [31:0] PC,
  output logic        Fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_pc_nxt;
  logic        w_load_instr;
  logic        w_load_pc;
  logic        w_timeout;

  assign w_pc_plus4 = r_pc + 32'd4;

  // Jump outranks branch; both are relative to the sequential successor.
  always_comb begin
    w_pc_nxt = w_pc_plus4;
    if (Jump) begin
      w_pc_nxt = {w_pc_plus4[31:28], Jump_target, 2'b00};
    end else if (Branch_taken) begin
      w_pc_nxt = w_pc_plus4 + {Ex_offset[29:0], 2'b00};
    end
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_wait_cnt;

  // Counter is held at zero outside FETCH, so every entry to FETCH starts it fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != FETCH) begin
      r_wait_cnt <= '0;
    end else if (!Imem_rdy) begin
      r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == FETCH) && !Imem_rdy &&
                     (r_wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
  assign Fetch_err = (r_state == ERR);
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout        = 1'b0;
  assign Fetch_err        = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_load_instr = 1'b0;
    w_load_pc    = 1'b0;
    case (r_state)
      IDLE: begin
        w_state_nxt = FETCH;
      end
      FETCH: begin
        if (Imem_rdy) begin
          w_state_nxt  = ISSUE;
          w_load_instr = 1'b1;
        end else if (w_timeout) begin
          w_state_nxt = ERR;
        end
      end
      ISSUE: begin
        if (Instr_ack) begin
          w_state_nxt = FETCH;
          w_load_pc   = 1'b1;
        end
      end
      ERR: begin
        w_state_nxt = ERR;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load_pc) begin
        r_pc <= w_pc_nxt;
      end
      if (w_load_instr) begin
        r_instr <= Imem_rdata;
      end
    end
  end

  // Request is a pure state decode so an asynchronous reset drops it immediately.
  assign Imem_req    = (r_state == FETCH);
  assign Imem_addr   = r_pc;
  assign PC          = r_pc;
  assign Instr       = r_instr;
  assign Instr_imm   = r_instr[15:0];
  assign Instr_valid = (r_state == ISSUE);

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus randomized fetch/issue traffic.
// Expectations follow FETCH_TIMEOUT_EN when the macro is defined for the build.
module tb_instr_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Imem_req;
  logic [31:0] Imem_addr;
  logic        Imem_rdy = 1'b0;
  logic [31:0] Imem_rdata = '0;
  logic [31:0] Instr;
  logic [15:0] Instr_imm;
  logic        Instr_valid;
  logic        Instr_ack = 1'b0;
  logic        Branch_taken = 1'b0;
  logic [31:0] Ex_offset = '0;
  logic        Jump = 1'b0;
  logic [25:0] Jump_target = '0;
  logic [31:0] PC;
  logic        Fetch_err;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_req;
  logic        m_err;

  instr_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Imem_req     (Imem_req),
    .Imem_addr    (Imem_addr),
    .Imem_rdy     (Imem_rdy),
    .Imem_rdata   (Imem_rdata),
    .Instr        (Instr),
    .Instr_imm    (Instr_imm),
    .Instr_valid  (Instr_valid),
    .Instr_ack    (Instr_ack),
    .Branch_taken (Branch_taken),
    .Ex_offset    (Ex_offset),
    .Jump         (Jump),
    .Jump_target  (Jump_target),
    .PC           (PC),
    .Fetch_err    (Fetch_err)
  );

  always #5 clk = ~clk;

  // Next-PC rule written as plain address arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic j,
                                             input logic b, input logic [31:0] off,
                                             input logic [25:0] tgt);
    logic [31:0] seq;
    seq = pc + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ({6'b0, tgt} * 32'd4);
    if (b) return seq + off * 32'd4;
    return seq;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_pc"},    PC,                  m_pc);
    chk({tag, "_addr"},  Imem_addr,           m_pc);
    chk({tag, "_instr"}, Instr,               m_instr);
    chk({tag, "_imm"},   {16'b0, Instr_imm},  {16'b0, m_instr[15:0]});
    chk({tag, "_valid"}, {31'b0, Instr_valid}, {31'b0, m_valid});
    chk({tag, "_req"},   {31'b0, Imem_req},   {31'b0, m_req});
    chk({tag, "_err"},   {31'b0, Fetch_err},  {31'b0, m_err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_controls();
    Instr_ack    = 1'($urandom_range(0, 1));
    Branch_taken = 1'($urandom_range(0, 1));
    Jump         = 1'($urandom_range(0, 1));
    Ex_offset    = $urandom;
    Jump_target  = 26'($urandom);
  endtask

  task automatic quiet_inputs();
    Imem_rdy     = 1'b0;
    Instr_ack    = 1'b0;
    Branch_taken = 1'b0;
    Jump         = 1'b0;
  endtask

  // Precondition: DUT is in FETCH. Leaves it holding the word in ISSUE.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      Imem_rdy   = 1'b0;
      Imem_rdata = $urandom;
      junk_controls();
      step();
      check_state("wait");
    end
    Imem_rdy   = 1'b1;
    Imem_rdata = word;
    junk_controls();
    step();
    quiet_inputs();
    m_instr = word;
    m_valid = 1'b1;
    m_req   = 1'b0;
    check_state("fetch");
  endtask

  // Precondition: DUT is in ISSUE. Leaves it in FETCH at the next PC.
  task automatic do_issue(input int holds, input logic j, input logic b,
                          input logic [31:0] off, input logic [25:0] tgt);
    for (int i = 0; i < holds; i++) begin
      Instr_ack    = 1'b0;
      Branch_taken = 1'($urandom_range(0, 1));
      Jump         = 1'($urandom_range(0, 1));
      Ex_offset    = $urandom;
      Jump_target  = 26'($urandom);
      Imem_rdy     = 1'($urandom_range(0, 1));
      Imem_rdata   = $urandom;
      step();
      check_state("hold");
    end
    Imem_rdy     = 1'($urandom_range(0, 1));
    Imem_rdata   = $urandom;
    Instr_ack    = 1'b1;
    Jump         = j;
    Branch_taken = b;
    Ex_offset    = off;
    Jump_target  = tgt;
    step();
    quiet_inputs();
    m_pc    = model_next(m_pc, j, b, off, tgt);
    m_valid = 1'b0;
    m_req   = 1'b1;
    check_state("ack");
  endtask

  // Pulses reset mid-cycle with a memory return pending; leaves DUT in FETCH at RST_PC.
  task automatic do_reset_pulse(input string tag);
    Imem_rdy   = 1'b1;
    Imem_rdata = $urandom;
    rst_n      = 1'b0;
    #1;
    m_pc    = RST_PC;
    m_instr = '0;
    m_valid = 1'b0;
    m_req   = 1'b0;
    m_err   = 1'b0;
    check_state(tag);
    #2;
    rst_n = 1'b1;
    step();
    m_req = 1'b1;
    check_state({tag, "_rel"});
    Imem_rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] off;
    m_pc    = RST_PC;
    m_instr = '0;
    m_valid = 1'b0;
    m_req   = 1'b0;
    m_err   = 1'b0;

    #1 rst_n = 1'b0;
    #1 check_state("reset");
    step();
    check_state("reset_edge");
    #6 rst_n = 1'b1;
    step();
    m_req = 1'b1;
    check_state("first_fetch");

    do_fetch(32'h2408_0005, 0);
    chk("r035_instr", Instr, 32'h2408_0005);
    chk("r035_imm", {16'b0, Instr_imm}, 32'h0000_0005);
    chk("r035_addr_held", Imem_addr, 32'h0000_3000);

    do_issue(2, 1'b0, 1'b0, 32'h0, 26'h0);
    chk("r036_seq", PC, 32'h0000_3004);

    do_fetch($urandom, 2);
    do_issue(1, 1'b0, 1'b0, $urandom, 26'($urandom));
    chk("seq_3008", PC, 32'h0000_3008);

    do_fetch($urandom, 1);
    do_issue(0, 1'b0, 1'b1, 32'hFFFF_FFFE, 26'h0);
    chk("r037_branch", PC, 32'h0000_3004);

    do_fetch($urandom, 1);
    do_reset_pulse("rst_issue");

    do_fetch($urandom, 0);
    do_issue(1, 1'b1, 1'b1, 32'h0000_0100, 26'h000_0C10);
    chk("r038_jump", PC, 32'h0000_3040);

    off = (32'hFFFF_FFFC - (m_pc + 32'd4)) >> 2;
    do_fetch($urandom, 0);
    do_issue(0, 1'b0, 1'b1, off, 26'h0);
    chk("branch_top", PC, 32'hFFFF_FFFC);
    do_fetch($urandom, 3);
    do_issue(0, 1'b0, 1'b0, $urandom, 26'($urandom));
    chk("r036_wrap", PC, 32'h0000_0000);

    for (int n = 0; n < 30; n++) begin
      do_fetch($urandom, $urandom_range(0, 5));
      do_issue($urandom_range(0, 3), ($urandom_range(0, 3) == 0),
               1'($urandom_range(0, 1)), $urandom, 26'($urandom));
    end

    for (int k = 1; k <= 20; k++) begin
      Imem_rdy = 1'b0;
      junk_controls();
      step();
`ifdef FETCH_TIMEOUT_EN
      if (k >= 16) begin
        m_err = 1'b1;
        m_req = 1'b0;
      end
`endif
      check_state("timeout");
    end
    quiet_inputs();

    do_reset_pulse("rst_after_wait");
    do_fetch($urandom, 2);
    do_issue(1, 1'b0, 1'b0, $urandom, 26'($urandom));
    do_reset_pulse("rst_fetch");
    do_fetch(32'hDEAD_BEEF, 1);
    do_issue(0, 1'b0, 1'b0, $urandom, 26'($urandom));
    chk("final_pc", PC, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
